data_sram_responder: RTL and testbench

Responder end of the CPU's data SRAM port: a synchronous byte-writable RAM plus a small memory-mapped I/O window holding an LED register, switch input, free-running timer, compare register and sticky interrupt flag. It sits outside `mycpu_top`, at the far end of `data_sram_en/we/addr/wdata/rdata`. It answers with fixed one-cycle read latency, so the CPU's MEM stage consumes `rdata` exactly one cycle after issuing the access in EXE.

---
 rtl/data_sram_responder_if.sv | 25 ++
 rtl/data_sram_responder.sv | 185 ++++++++++++++++++
 tb/tb_data_sram_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Data SRAM port between the CPU (master) and the data_sram_responder (slave).
// The master presents en/we/addr/wdata; the slave returns rdata one cycle later.
interface data_sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable RAM with fixed one-cycle read latency.
// Define DATA_SRAM_IO_EN to add the MMIO window (LED, SWITCH, TIMER, TIMER_CMP, IRQ_STAT).
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [31:0] IO_BASE = 32'hbfaf_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  data_sram_responder_if.slave sram,
  input  logic [7:0]           switch,
  output logic [15:0]          led,
  output logic                 timer_irq
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] word_idx_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  word_idx_t ram_idx;
  logic      access_wr;
  logic      io_hit;
  logic      ram_wr;

  assign ram_idx   = sram.sram_addr[ADDR_W+1:2];
  assign access_wr = sram.sram_en && (|sram.sram_we);

`ifdef DATA_SRAM_IO_EN
  assign io_hit = (sram.sram_addr[31:16] == IO_BASE[31:16]);
`else
  assign io_hit = 1'b0;
`endif

  // An edge that arrives while reset is held must not commit a pending write.
  assign ram_wr = access_wr && !io_hit && resetn;

  // ---------------------------------------------------------------------------
  // RAM array
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset branch; clearing 2^ADDR_W words would defeat
  // RAM inference, and software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.sram_we[i]) mem[ram_idx][8*i +: 8] <= sram.sram_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MMIO window
  // ---------------------------------------------------------------------------
  logic [31:0] io_rdata;

`ifdef DATA_SRAM_IO_EN
  localparam logic [13:0] REG_LED    = 14'h0000;
  localparam logic [13:0] REG_SWITCH = 14'h0001;
  localparam logic [13:0] REG_TIMER  = 14'h0002;
  localparam logic [13:0] REG_CMP    = 14'h0003;
  localparam logic [13:0] REG_IRQ    = 14'h0004;

  logic [13:0] io_word;
  logic        io_wr;
  logic        led_wr, timer_wr, cmp_wr, irq_wr;

  assign io_word = sram.sram_addr[15:2];
  assign io_wr   = access_wr && io_hit;

  always_comb begin
    led_wr   = io_wr && (io_word == REG_LED);
    timer_wr = io_wr && (io_word == REG_TIMER);
    cmp_wr   = io_wr && (io_word == REG_CMP);
    irq_wr   = io_wr && (io_word == REG_IRQ);
  end

  logic [15:0] led_q,     led_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;
  logic [31:0] timer_q,   timer_d;
  logic [31:0] cmp_q,     cmp_d;
  logic        irq_q,     irq_d;
  logic [31:0] led_merged;
  logic        irq_set, irq_clr;

  // NOTE: every comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    led_merged = byte_merge({16'h0000, led_q}, sram.sram_wdata, sram.sram_we);
    led_d      = led_wr ? led_merged[15:0] : led_q;

    sw_meta_d  = switch;
    sw_sync_d  = sw_meta_q;

    // A software load takes the place of that cycle's increment.
    timer_d    = timer_wr ? byte_merge(timer_q, sram.sram_wdata, sram.sram_we)
                          : timer_q + 32'd1;
    cmp_d      = cmp_wr ? byte_merge(cmp_q, sram.sram_wdata, sram.sram_we) : cmp_q;

    // A zero compare value disarms the match; a match beats a same-cycle clear.
    irq_set    = (timer_q == cmp_q) && (cmp_q != 32'h0);
    irq_clr    = irq_wr && sram.sram_we[0] && sram.sram_wdata[0];
    irq_d      = irq_q;
    if (irq_set)      irq_d = 1'b1;
    else if (irq_clr) irq_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      timer_q   <= '0;
      cmp_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    io_rdata = 32'h0;
    unique case (io_word)
      REG_LED:    io_rdata = {16'h0000, led_q};
      REG_SWITCH: io_rdata = {24'h00_0000, sw_sync_q};
      REG_TIMER:  io_rdata = timer_q;
      REG_CMP:    io_rdata = cmp_q;
      REG_IRQ:    io_rdata = {31'h0, irq_q};
      default:    io_rdata = 32'h0;
    endcase
  end

  assign led       = led_q;
  assign timer_irq = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, sram.sram_addr[1:0]};
`else
  assign io_rdata  = 32'h0;
  assign led       = 16'h0000;
  assign timer_irq = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, switch, sram.sram_addr[1:0], sram.sram_addr[31:ADDR_W+2]};
`endif

  // ---------------------------------------------------------------------------
  // Read data register: read-first, holds while the port is idle
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (sram.sram_en) rdata_d = io_hit ? io_rdata : mem[ram_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign sram.sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed vector table, hand sequences
// for timer/IRQ/reset corners, and random traffic against a transaction-level model.
module tb_data_sram_responder;

  localparam logic [31:0] IO = 32'hbfaf_0000;

  logic        clk;
  logic        resetn;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        timer_irq;

  data_sram_responder_if bus ();

  data_sram_responder dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram      (bus.slave),
    .switch    (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: word-addressed memory plus register values
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_timer, m_cmp;
  logic        m_irq;
  logic [7:0]  m_s1, m_s2;
  logic [31:0] exp_rd;
  bit          exp_known;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] io_value(input logic [15:0] off);
    case (off)
      16'h0000: return {16'h0, m_led};
      16'h0004: return {24'h0, m_s2};
      16'h0008: return m_timer;
      16'h000C: return m_cmp;
      16'h0010: return {31'h0, m_irq};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_timer = '0; m_cmp = '0; m_irq = 1'b0;
    m_s1 = '0; m_s2 = '0; exp_rd = '0; exp_known = 1'b1;
  endtask

  task automatic model_step(input bit en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wd);
    int          widx;
    logic [15:0] off;
    bit          io, set_c, clr_c, twr;
    logic [31:0] tmp;
    widx = int'(addr[15:2]);
    off  = {addr[15:2], 2'b00};
`ifdef DATA_SRAM_IO_EN
    io = (addr[31:16] == 16'hbfaf);
`else
    io = 1'b0;
`endif
    set_c = (m_timer == m_cmp) && (m_cmp != 0);
    clr_c = en && io && (off == 16'h0010) && we[0] && wd[0];
    twr   = 1'b0;
    if (en) begin
      if (io) begin
        exp_rd = io_value(off); exp_known = 1'b1;
      end else if (m_mem.exists(widx)) begin
        exp_rd = m_mem[widx]; exp_known = 1'b1;
      end else begin
        exp_known = 1'b0;
      end
    end
    if (en && we != 0) begin
      if (io) begin
        case (off)
          16'h0000: begin tmp = merge({16'h0, m_led}, wd, we); m_led = tmp[15:0]; end
          16'h0008: begin m_timer = merge(m_timer, wd, we); twr = 1'b1; end
          16'h000C: m_cmp = merge(m_cmp, wd, we);
          default: ;
        endcase
      end else if (m_mem.exists(widx)) begin
        m_mem[widx] = merge(m_mem[widx], wd, we);
      end else if (we == 4'hF) begin
        m_mem[widx] = wd;
      end
    end
    if (!twr) m_timer = m_timer + 32'd1;
    if (set_c) m_irq = 1'b1;
    else if (clr_c) m_irq = 1'b0;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  // One clock cycle: drive the access, advance the model, settle just past the edge.
  task automatic cyc(input bit en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wd);
    bus.sram_en = en; bus.sram_we = we; bus.sram_addr = addr; bus.sram_wdata = wd;
    model_step(en, we, addr, wd);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{1'b1, 4'hF,    32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD, 1'b1, 32'h1122_3344};
    vt[2]  = '{1'b1, 4'h0,    32'h0000_0100, 32'h0,         1'b1, 32'h11BB_33DD};
    vt[3]  = '{1'b0, 4'hF,    32'h0000_0100, 32'h0,         1'b1, 32'h11BB_33DD};
    vt[4]  = '{1'b0, 4'h0,    32'h0000_0200, 32'hFFFF_FFFF, 1'b1, 32'h11BB_33DD};
    vt[5]  = '{1'b0, 4'h0,    32'h0000_0000, 32'h0,         1'b1, 32'h11BB_33DD};
    vt[6]  = '{1'b1, 4'hF,    32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 4'hF,    32'h0000_0200, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 4'h0,    32'h0000_0200, 32'h0,         1'b1, 32'h0};
    vt[9]  = '{1'b1, 4'h0,    32'h0001_0103, 32'h0,         1'b1, 32'h11BB_33DD};
    vt[10] = '{1'b1, 4'h0,    32'h0000_0202, 32'h0,         1'b1, 32'h0};

    resetn = 1'b0; sw = 8'h00;
    bus.sram_en = 1'b0; bus.sram_we = '0; bus.sram_addr = '0; bus.sram_wdata = '0;
    model_reset();
    #22;
    check("reset_rdata", bus.sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, timer_irq}, 32'h0);
    resetn = 1'b1;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);

    // Directed RAM vectors: byte lanes, read-first, hold, aliasing
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].en, vt[i].we, vt[i].addr, vt[i].wdata);
      if (vt[i].chk) check($sformatf("vec%0d", i), bus.sram_rdata, vt[i].exp);
    end

`ifdef DATA_SRAM_IO_EN
    // LED with byte enables
    cyc(1'b1, 4'b0011, IO + 32'h0, 32'hFFFF_A5A5);
    check("led_a5a5", {16'h0, led}, 32'h0000_A5A5);
    cyc(1'b1, 4'b0010, IO + 32'h0, 32'h0000_1200);
    check("led_lane1", {16'h0, led}, 32'h0000_12A5);
    cyc(1'b1, 4'h0, IO + 32'h0, 32'h0);
    check("led_read", bus.sram_rdata, 32'h0000_12A5);

    // SWITCH synchroniser latency
    sw = 8'h3C;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, IO + 32'h4, 32'h0);
    check("switch_3c", bus.sram_rdata, 32'h0000_003C);
    sw = 8'h81;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, IO + 32'h4, 32'h0);
    check("switch_early", bus.sram_rdata, 32'h0000_003C);
    cyc(1'b1, 4'h0, IO + 32'h4, 32'h0);
    check("switch_81", bus.sram_rdata, 32'h0000_0081);

    // Timer wrap, compare match, sticky flag, W1C
    cyc(1'b1, 4'hF, IO + 32'h8, 32'hFFFF_FFFE);
    cyc(1'b1, 4'hF, IO + 32'hC, 32'h0000_0001);
    check("irq_pre0", {31'h0, timer_irq}, 32'h0);
    cyc(1'b1, 4'h0, IO + 32'h8, 32'h0);
    check("timer_ffff", bus.sram_rdata, 32'hFFFF_FFFF);
    cyc(1'b1, 4'h0, IO + 32'h8, 32'h0);
    check("timer_wrap", bus.sram_rdata, 32'h0);
    check("irq_pre1", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    check("irq_rise", {31'h0, timer_irq}, 32'h1);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    check("irq_sticky", {31'h0, timer_irq}, 32'h1);
    cyc(1'b1, 4'h0, IO + 32'h10, 32'h0);
    check("irq_stat_rd", bus.sram_rdata, 32'h1);
    cyc(1'b1, 4'b0001, IO + 32'h10, 32'h1);
    check("irq_w1c", {31'h0, timer_irq}, 32'h0);

    // Write beats increment; set beats W1C
    cyc(1'b1, 4'hF, IO + 32'h8, 32'h0000_0050);
    cyc(1'b1, 4'h0, IO + 32'h8, 32'h0);
    check("timer_load", bus.sram_rdata, 32'h0000_0050);
    cyc(1'b1, 4'hF, IO + 32'hC, 32'h0000_0052);
    cyc(1'b1, 4'b0001, IO + 32'h10, 32'h1);
    check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    cyc(1'b1, 4'b0001, IO + 32'h10, 32'h1);
    check("irq_clr2", {31'h0, timer_irq}, 32'h0);

    // Zero compare never fires
    cyc(1'b1, 4'hF, IO + 32'hC, 32'h0);
    cyc(1'b1, 4'hF, IO + 32'h8, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'h0, 32'h0, 32'h0);
      check($sformatf("irq_cmp0_%0d", i), {31'h0, timer_irq}, 32'h0);
    end
`else
    // Without the window, the I/O base is plain aliased RAM
    cyc(1'b1, 4'hF, IO + 32'h8, 32'hCAFE_0001);
    check("noio_led", {16'h0, led}, 32'h0);
    cyc(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    check("noio_alias", bus.sram_rdata, 32'hCAFE_0001);
    check("noio_irq", {31'h0, timer_irq}, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'hF, 32'(i) << 2, $urandom);
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      bit          en;
      logic [3:0]  we;
      logic [31:0] a, d;
      logic [15:0] hi;
      logic [15:0] off;
      r  = $urandom_range(0, 9);
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d  = $urandom;
      if (r < 5) begin
        hi = 16'($urandom);
        if (hi == 16'hbfaf) hi = 16'h0;
        a = {hi, 10'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      end else if (r < 9) begin
        case ($urandom_range(0, 6))
          0: off = 16'h0000;
          1: off = 16'h0004;
          2: off = 16'h0008;
          3: off = 16'h000C;
          4: off = 16'h0010;
          5: off = 16'h0014;
          default: off = 16'h003C;
        endcase
        a = {16'hbfaf, off};
        if (off == 16'h000C) d = m_timer + 32'($urandom_range(1, 4));
      end else begin
        sw = 8'($urandom);
        en = 1'b0;
        a  = $urandom;
      end
      cyc(en, we, a, d);
      if (exp_known) check($sformatf("rnd_rdata%0d", n), bus.sram_rdata, exp_rd);
      check($sformatf("rnd_led%0d", n), {16'h0, led}, {16'h0, m_led});
      check($sformatf("rnd_irq%0d", n), {31'h0, timer_irq}, {31'h0, m_irq});
    end

    // Asynchronous reset in the middle of a write
`ifdef DATA_SRAM_IO_EN
    cyc(1'b1, 4'hF, IO + 32'hC, 32'h5);
    cyc(1'b1, 4'hF, IO + 32'h8, 32'h3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    check("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
    cyc(1'b1, 4'hF, IO + 32'h0, 32'h0000_BEEF);
`endif
    cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("pre_rst_rdata", bus.sram_rdata, 32'h11BB_33DD);
    bus.sram_en = 1'b1; bus.sram_we = 4'hF; bus.sram_addr = 32'h0000_0100; bus.sram_wdata = 32'h0;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_rdata", bus.sram_rdata, 32'h0);
    check("rst_async_led", {16'h0, led}, 32'h0);
    check("rst_async_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
`ifdef DATA_SRAM_IO_EN
    cyc(1'b1, 4'h0, IO + 32'h8, 32'h0);
    check("rst_timer", bus.sram_rdata, 32'h0);
`endif
    cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("rst_discard_wr", bus.sram_rdata, 32'h11BB_33DD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
